zbuffer_writer: RTL and testbench
=================================

Name: zbuffer_writer

Overview:
Sink end of the rasterizer pixel stream. It accepts (x, y, depth, drawing) each cycle and depth-tests every pixel against an internal depth RAM. Pixels that pass update the depth RAM and issue a framebuffer write of the supplied colour. It also owns the per-frame clear of both the depth RAM and the framebuffer.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 180, framebuffer height in pixels
COORD_WIDTH, 32, width of the signed x/y inputs
DEPTH_BIT_WIDTH, 16, depth value width
COLOR_WIDTH, 16, framebuffer pixel width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
x  input  COORD_WIDTH  signed pixel x
y  input  COORD_WIDTH  signed pixel y
depth  input  DEPTH_BIT_WIDTH  pixel depth; smaller is closer
drawing  input  1  pixel valid this cycle
color  input  COLOR_WIDTH  colour for this pixel
clear_start  input  1  pulse: clear depth RAM and framebuffer
clear_color  input  COLOR_WIDTH  framebuffer clear value
fb_we  output  1  framebuffer write enable
fb_addr  output  $clog2(FB_WIDTH*FB_HEIGHT)  write address, y*FB_WIDTH+x
fb_data  output  COLOR_WIDTH  write data
busy  output  1  high from clear acceptance through clear_done
clear_done  output  1  one-cycle pulse at end of clear
pixels_written  output  32  count of passed pixels
pixels_rejected  output  32  count of depth-failed pixels

Behaviour:
- Reset: async assert forces state IDLE. fb_we, fb_addr, fb_data, busy, clear_done and both counters go to 0, and pipeline valids and forwarding history are cleared. Depth RAM contents are not reset; a clear is required before the first frame.
- Depth RAM: FB_WIDTH*FB_HEIGHT x DEPTH_BIT_WIDTH, one read port and one write port, read latency 2. A read issued in cycle t returns contents as of the end of cycle t-1.
- Pixel pipeline, fixed latency of 3 cycles from drawing sample to fb_we:
  - S1: accept when drawing=1 and state IDLE. Drop if x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT; dropped pixels are not counted. Otherwise compute addr and issue the depth read.
  - S2: carry addr, depth and colour forward.
  - S3: stored = forwarded value if a hit, else RAM data. Pass iff depth < stored (strict). On pass: write depth to RAM, fb_we=1, fb_addr=addr, fb_data=colour, pixels_written+1. On fail: fb_we=0, pixels_rejected+1.
- Forwarding: keep a 2-entry history of (addr, depth) for the S3 writes of the previous two cycles. If the S3 addr matches, use the newest matching entry. This covers back-to-back duplicate pixels.
- Throughput: 1 pixel per cycle, no stall.
- States: IDLE, DRAIN, CLEAR, DONE.
  - IDLE -> DRAIN on clear_start. Counters zero in the same cycle and busy goes to 1.
  - DRAIN: lasts 3 cycles. Pixels already in S1-S3 complete normally; new drawing inputs are dropped.
  - CLEAR: forwarding history is invalidated on entry. A counter walks 0..N-1, one address per cycle. Each cycle writes depth all-ones and fb_we=1, fb_data=clear_color.
  - DONE: 1 cycle, clear_done=1, busy=0, then IDLE.
- clear_start while not IDLE is ignored. clear_color is sampled once on acceptance.
- drawing and clear_start in the same IDLE cycle: the pixel is accepted and completes during DRAIN.
- Counters saturate at 2^32-1.
- Reset mid-clear: return immediately to IDLE; RAM is left partially cleared.

Test Plan:
- Reset, then clear_start with clear_color=16'h1234 -> busy rises next cycle; 3 drain cycles; exactly 57600 fb writes at addresses 0..57599 with data 16'h1234; clear_done pulses once; busy=0.
- After clear, pixel (10,5,depth=100,color=A) -> fb_we 3 cycles later at addr 1610, data A; pixels_written=1.
- Then (10,5,depth=200) -> no write, pixels_rejected=1. Then (10,5,depth=50,color=B) -> write B.
- Back-to-back cycles at (3,3) with depths 300, 200, 250 -> writes for 300 and 200 only; 250 rejected via forwarding; written=2, rejected=1.
- Pixels (-1,0), (320,0), (0,180) with drawing=1 -> no fb_we and both counters unchanged.
- Assert rst_in mid-clear at address 1000 -> outputs 0 asynchronously; after release busy=0; a new clear_start completes all 57600 writes.

Source files
------------

// File: rtl/zbuffer_writer.sv
// zbuffer_writer: depth-tested pixel sink for the rasterizer stream.
// Each in-bounds pixel is looked up in an internal depth RAM, compared
// against the stored depth (with forwarding for recent writes), and on a
// strict pass the RAM is updated and a framebuffer write is issued.
// The block also sequences the per-frame clear of depth RAM and framebuffer.
module zbuffer_writer #(
    parameter int FB_WIDTH        = 320,
    parameter int FB_HEIGHT       = 180,
    parameter int COORD_WIDTH     = 32,
    parameter int DEPTH_BIT_WIDTH = 16,
    parameter int COLOR_WIDTH     = 16,
    localparam int NPIX           = FB_WIDTH * FB_HEIGHT,
    localparam int AW             = $clog2(NPIX)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [COORD_WIDTH-1:0] x,
    input  logic signed [COORD_WIDTH-1:0] y,
    input  logic [DEPTH_BIT_WIDTH-1:0]    depth,
    input  logic                          drawing,
    input  logic [COLOR_WIDTH-1:0]        color,
    input  logic                          clear_start,
    input  logic [COLOR_WIDTH-1:0]        clear_color,
    output logic                          fb_we,
    output logic [AW-1:0]                 fb_addr,
    output logic [COLOR_WIDTH-1:0]        fb_data,
    output logic                          busy,
    output logic                          clear_done,
    output logic [31:0]                   pixels_written,
    output logic [31:0]                   pixels_rejected
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

    state_t                      state;
    logic [1:0]                  drain_cnt;
    logic [AW-1:0]               clr_cnt;
    logic [COLOR_WIDTH-1:0]      clear_color_q;

    // S1 (combinational, input side)
    logic                        accept;
    logic [AW-1:0]               addr_s1;

    // S1 -> S2 registers
    logic                        vld_p0;
    logic [AW-1:0]               addr_p0;
    logic [DEPTH_BIT_WIDTH-1:0]  depth_p0;
    logic [COLOR_WIDTH-1:0]      color_p0;

    // S2 -> S3 registers
    logic                        vld_p1;
    logic [AW-1:0]               addr_p1;
    logic [DEPTH_BIT_WIDTH-1:0]  depth_p1;
    logic [COLOR_WIDTH-1:0]      color_p1;
    logic [DEPTH_BIT_WIDTH-1:0]  rd_data_p1;

    // Forwarding history of the last two S3 depth writes (0 is newest)
    logic                        fwd0_vld, fwd1_vld;
    logic [AW-1:0]               fwd0_addr, fwd1_addr;
    logic [DEPTH_BIT_WIDTH-1:0]  fwd0_depth, fwd1_depth;

    // S3 (combinational, depth test)
    logic [DEPTH_BIT_WIDTH-1:0]  stored;
    logic                        pass;
    logic                        reject;

    // Depth RAM write port
    logic                        ram_we;
    logic [AW-1:0]               ram_waddr;
    logic [DEPTH_BIT_WIDTH-1:0]  ram_wdata;
    logic [DEPTH_BIT_WIDTH-1:0]  depth_mem [0:NPIX-1];

    logic                        enter_clear;

    function automatic logic in_bounds(input logic signed [COORD_WIDTH-1:0] px,
                                       input logic signed [COORD_WIDTH-1:0] py);
        logic signed [COORD_WIDTH-1:0] w;
        logic signed [COORD_WIDTH-1:0] h;
        w = $signed(COORD_WIDTH'(FB_WIDTH));
        h = $signed(COORD_WIDTH'(FB_HEIGHT));
        return (px >= 0) && (px < w) && (py >= 0) && (py < h);
    endfunction

    function automatic logic [AW-1:0] calc_addr(input logic [AW-1:0] px,
                                                input logic [AW-1:0] py);
        return py * AW'(FB_WIDTH) + px;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Accept decision and linear address for the incoming pixel
    always_comb begin
        accept  = drawing && (state == IDLE) && in_bounds(x, y);
        addr_s1 = calc_addr(x[AW-1:0], y[AW-1:0]);
    end

    // Depth test using the newest forwarded write when the address matches
    always_comb begin
        stored = rd_data_p1;
        if (fwd0_vld && (fwd0_addr == addr_p1))
            stored = fwd0_depth;
        else if (fwd1_vld && (fwd1_addr == addr_p1))
            stored = fwd1_depth;
        pass   = vld_p1 && (depth_p1 < stored);
        reject = vld_p1 && !(depth_p1 < stored);
    end

    // RAM write mux: clear sweep owns the port; the pipeline is empty then
    always_comb begin
        enter_clear = (state == DRAIN) && (drain_cnt == 2'd2);
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = '1;
        end else begin
            ram_we    = pass;
            ram_waddr = addr_p1;
            ram_wdata = depth_p1;
        end
    end

    // Pipeline valid bits
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
        end
    end

    // Pipeline data: S1 -> S2 -> S3
    always_ff @(posedge clk_in) begin
        if (accept) begin
            addr_p0  <= addr_s1;
            depth_p0 <= depth;
            color_p0 <= color;
        end
        addr_p1  <= addr_p0;
        depth_p1 <= depth_p0;
        color_p1 <= color_p0;
    end

    // Depth RAM: registered read of the S2 address, single write port
    always_ff @(posedge clk_in) begin
        if (ram_we)
            depth_mem[ram_waddr] <= ram_wdata;
        rd_data_p1 <= depth_mem[addr_p0];
    end

    // Forwarding history shift; wiped when the clear sweep begins
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fwd0_vld <= 1'b0;
            fwd1_vld <= 1'b0;
        end else if (enter_clear) begin
            fwd0_vld <= 1'b0;
            fwd1_vld <= 1'b0;
        end else begin
            fwd1_vld <= fwd0_vld;
            fwd0_vld <= pass;
        end
    end

    // Forwarding history payload
    always_ff @(posedge clk_in) begin
        fwd1_addr  <= fwd0_addr;
        fwd1_depth <= fwd0_depth;
        fwd0_addr  <= addr_p1;
        fwd0_depth <= depth_p1;
    end

    // Control FSM with registered framebuffer port, status and counters
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            drain_cnt       <= 2'd0;
            clr_cnt         <= '0;
            clear_color_q   <= '0;
            busy            <= 1'b0;
            clear_done      <= 1'b0;
            fb_we           <= 1'b0;
            fb_addr         <= '0;
            fb_data         <= '0;
            pixels_written  <= 32'd0;
            pixels_rejected <= 32'd0;
        end else begin
            fb_we <= pass;
            if (pass) begin
                fb_addr <= addr_p1;
                fb_data <= color_p1;
            end
            if (pass)
                pixels_written <= sat_inc(pixels_written);
            if (reject)
                pixels_rejected <= sat_inc(pixels_rejected);

            case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_start) begin
                        state           <= DRAIN;
                        drain_cnt       <= 2'd0;
                        busy            <= 1'b1;
                        clear_color_q   <= clear_color;
                        pixels_written  <= 32'd0;
                        pixels_rejected <= 32'd0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                CLEAR: begin
                    fb_we   <= 1'b1;
                    fb_addr <= clr_cnt;
                    fb_data <= clear_color_q;
                    if (clr_cnt == AW'(NPIX - 1)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                DONE: begin
                    fb_we      <= 1'b0;
                    clear_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zbuffer_writer.sv
// Scoreboard bench for zbuffer_writer: expected framebuffer writes are queued
// as stimulus is driven and checked in order by a write monitor.
module tb_zbuffer_writer;

    localparam int W = 320;
    localparam int H = 180;
    localparam int N = W * H;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic signed [31:0] x, y;
    logic [15:0]        depth;
    logic               drawing;
    logic [15:0]        color;
    logic               clear_start;
    logic [15:0]        clear_color;
    logic               fb_we;
    logic [15:0]        fb_addr;
    logic [15:0]        fb_data;
    logic               busy;
    logic               clear_done;
    logic [31:0]        pixels_written;
    logic [31:0]        pixels_rejected;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  done_pulses = 0;

    zbuffer_writer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .x               (x),
        .y               (y),
        .depth           (depth),
        .drawing         (drawing),
        .color           (color),
        .clear_start     (clear_start),
        .clear_color     (clear_color),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_data         (fb_data),
        .busy            (busy),
        .clear_done      (clear_done),
        .pixels_written  (pixels_written),
        .pixels_rejected (pixels_rejected)
    );

    always #5 clk_in = ~clk_in;

    // Write monitor: every framebuffer write must match the queue head
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (clear_done) done_pulses++;
            if (fb_we) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", fb_addr, fb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (fb_addr !== mon_e.addr || fb_data !== mon_e.data) begin
                        bad++;
                        $display("FAIL fb_write got addr=%0d data=%h expected addr=%0d data=%h",
                                 fb_addr, fb_data, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic set_pixel(input int px, input int py, input int d, input logic [15:0] c);
        x = px; y = py; depth = 16'(d); color = c; drawing = 1'b1;
    endtask

    task automatic push_write(input int px, input int py, input logic [15:0] c);
        wr_t e;
        e.addr = 16'(py * W + px);
        e.data = c;
        exp_q.push_back(e);
    endtask

    task automatic check_counts(input string name, input int wr, input int rj);
        total++;
        if (pixels_written !== 32'(wr) || pixels_rejected !== 32'(rj)) begin
            bad++;
            $display("FAIL %s counters got written=%0d rejected=%0d expected written=%0d rejected=%0d",
                     name, pixels_written, pixels_rejected, wr, rj);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        total++;
        if (fb_we !== 1'b0 || fb_addr !== 16'd0 || fb_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_fb got we=%b addr=%0d data=%h expected 0", fb_we, fb_addr, fb_data);
        end
        total++;
        if (busy !== 1'b0 || clear_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got busy=%b done=%b expected 0", busy, clear_done);
        end
        check_counts("reset", 0, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Full clear; a pixel offered during DRAIN must be dropped
    task automatic do_clear(input logic [15:0] cc);
        int cyc;
        wr_t e;
        @(posedge clk_in); #1;
        clear_color = cc;
        clear_start = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.addr = 16'(i);
            e.data = cc;
            exp_q.push_back(e);
        end
        @(posedge clk_in); #1;
        clear_start = 1'b0;
        clear_color = ~cc;
        set_pixel(1, 1, 0, 16'hDEAD);
        @(negedge clk_in);
        done_pulses = 0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_busy_rise got busy=%b expected 1", busy);
        end
        check_counts("clear_zero", 0, 0);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        cyc = 0;
        while (done_pulses == 0 && cyc < 60000) begin
            @(negedge clk_in);
            cyc++;
        end
        repeat (3) @(negedge clk_in);
        total++;
        if (done_pulses !== 1) begin
            bad++;
            $display("FAIL clear_done_pulses got %0d expected 1", done_pulses);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_busy_end got busy=%b expected 0", busy);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL clear_write_count got %0d missing writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        int  cyc;
        bit  hit;
        wr_t e;
        @(posedge clk_in); #1;
        clear_color = 16'h5A5A;
        clear_start = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.addr = 16'(i);
            e.data = 16'h5A5A;
            exp_q.push_back(e);
        end
        @(posedge clk_in); #1;
        clear_start = 1'b0;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 5000) begin
            @(negedge clk_in);
            cyc++;
            if (fb_we === 1'b1 && fb_addr === 16'd1000) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midclear_reach got no write at addr 1000 within %0d cycles", cyc);
        end
        #2 rst_in = 1'b1;
        #1;
        exp_q.delete();
        total++;
        if (fb_we !== 1'b0 || fb_addr !== 16'd0 || fb_data !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midclear_async got we=%b addr=%0d data=%h busy=%b expected 0",
                     fb_we, fb_addr, fb_data, busy);
        end
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        @(negedge clk_in);
        total++;
        if (busy !== 1'b0 || fb_we !== 1'b0) begin
            bad++;
            $display("FAIL midclear_release got busy=%b we=%b expected 0", busy, fb_we);
        end
    endtask

    task automatic test_pixel();
        @(posedge clk_in); #1;
        set_pixel(10, 5, 100, 16'hAAAA);
        push_write(10, 5, 16'hAAAA);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        total++;
        if (fb_we !== 1'b1 || fb_addr !== 16'd1610) begin
            bad++;
            $display("FAIL pixel_latency got we=%b addr=%0d expected we=1 addr=1610", fb_we, fb_addr);
        end
        repeat (2) @(negedge clk_in);
        check_counts("pixel_first", 1, 0);

        @(posedge clk_in); #1;
        set_pixel(10, 5, 200, 16'h1111);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("pixel_farther", 1, 1);

        @(posedge clk_in); #1;
        set_pixel(10, 5, 50, 16'hBBBB);
        push_write(10, 5, 16'hBBBB);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("pixel_nearer", 2, 1);
    endtask

    task automatic test_back_to_back();
        @(posedge clk_in); #1;
        set_pixel(3, 3, 300, 16'hC300);
        push_write(3, 3, 16'hC300);
        @(posedge clk_in); #1;
        set_pixel(3, 3, 200, 16'hC200);
        push_write(3, 3, 16'hC200);
        @(posedge clk_in); #1;
        set_pixel(3, 3, 250, 16'hC250);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("b2b_dup", 4, 2);

        @(posedge clk_in); #1;
        set_pixel(4, 4, 10, 16'hD001);
        push_write(4, 4, 16'hD001);
        @(posedge clk_in); #1;
        set_pixel(5, 4, 10, 16'hD002);
        push_write(5, 4, 16'hD002);
        @(posedge clk_in); #1;
        set_pixel(4, 4, 5, 16'hD003);
        push_write(4, 4, 16'hD003);
        @(posedge clk_in); #1;
        set_pixel(4, 4, 7, 16'hD004);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("b2b_interleave", 7, 3);
    endtask

    task automatic test_bounds();
        @(posedge clk_in); #1;
        set_pixel(-1, 0, 1, 16'hE001);
        @(posedge clk_in); #1;
        set_pixel(320, 0, 1, 16'hE002);
        @(posedge clk_in); #1;
        set_pixel(0, 180, 1, 16'hE003);
        @(posedge clk_in); #1;
        set_pixel(0, -1, 1, 16'hE004);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("bounds_drop", 7, 3);

        @(posedge clk_in); #1;
        set_pixel(319, 179, 1, 16'hE005);
        push_write(319, 179, 16'hE005);
        @(posedge clk_in); #1;
        drawing = 1'b0;
        repeat (5) @(negedge clk_in);
        check_counts("bounds_corner", 8, 3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_writes got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst_in      = 1'b0;
        x           = 0;
        y           = 0;
        depth       = 16'd0;
        drawing     = 1'b0;
        color       = 16'd0;
        clear_start = 1'b0;
        clear_color = 16'd0;
        test_reset();
        test_reset_mid_clear();
        do_clear(16'h1234);
        test_pixel();
        test_back_to_back();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
